branch_inflight_queue: RTL and testbench

In-order queue of predicted-but-unresolved branches. It sits beside the gshare predictor. It forwards each accepted branch PC to the predictor's lookup port and captures the taken/not-taken prediction the predictor returns one cycle later. When the branch outcome resolves, it drives the predictor's update port with the PC and actual direction, and flags mispredictions.

---
 rtl/biq_pkg.sv | 28 ++
 rtl/biq_stats.sv | 37 +++
 rtl/branch_inflight_queue.sv | 157 +++++++++++++++
 tb/tb_branch_inflight_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : biq_pkg
// Description : Shared types and helpers for branch in-flight style queues
//               (branch queue today, BTB/return-stack queues later).
// Revision    : 1.0 - initial release
// ============================================================================
package biq_pkg;

  // Widest PC any queue built on this package will carry; narrower PCs are
  // zero-extended into the entry.
  localparam int c_PC_W_MAX = 64;

  // One queue slot: branch PC, predicted direction, and whether the
  // prediction has been captured from the predictor yet.
  typedef struct packed {
    logic [c_PC_W_MAX-1:0] pc;
    logic                  pred;
    logic                  pred_vld;
  } biq_entry_t;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/biq_stats.sv
`default_nettype none
// ============================================================================
// Module      : biq_stats
// Description : Saturating counters of emitted predictor updates and of
//               mispredicted branches. Reset clears them; flush does not.
// Revision    : 1.0 - initial release
// ============================================================================
module biq_stats
  import biq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_update_valid,
  input  logic        i_mispredict,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_mispred_cnt
);

  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  // Count every emitted update and every flagged mispredict, saturating.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (i_update_valid) r_branch_cnt <= sat_inc32(r_branch_cnt);
      if (i_mispredict)   r_mispred_cnt <= sat_inc32(r_mispred_cnt);
    end
  end

  assign o_branch_cnt  = r_branch_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: rtl/branch_inflight_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_inflight_queue
// Description : In-order queue of predicted-but-unresolved branches beside
//               the gshare predictor. Forwards accepted PCs to the predictor
//               lookup, captures the prediction one cycle later, and on
//               resolve drives the predictor update port and flags
//               mispredictions.
//               Optional feature: define BIQ_STATS_EN to enable the
//               branch / mispredict statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_inflight_queue
  import biq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_alloc_valid,
  input  logic [PC_W-1:0]        i_alloc_pc,
  output logic                   o_alloc_ready,
  output logic                   o_pred_valid,
  output logic [PC_W-1:0]        o_pred_pc,
  input  logic                   i_pred_taken,
  input  logic                   i_resolve_valid,
  input  logic                   i_resolve_taken,
  output logic                   o_resolve_ready,
  output logic                   o_update_valid,
  output logic [PC_W-1:0]        o_update_pc,
  output logic                   o_result_taken,
  output logic                   o_mispredict,
  output logic                   o_head_pred,
  output logic [$clog2(DEPTH):0] o_count,
  input  logic                   i_flush,
  output logic [31:0]            o_branch_cnt,
  output logic [31:0]            o_mispred_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  biq_entry_t         r_entries [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_pend_valid;
  logic [c_PTR_W-1:0] r_pend_idx;

  logic               r_update_valid;
  logic [PC_W-1:0]    r_update_pc;
  logic               r_result_taken;
  logic               r_mispredict;

  logic               w_alloc_acc;
  logic               w_res_acc;
  logic               w_head_pred;

  // Readiness depends only on registered state; a resolve in this cycle
  // never frees room for an alloc in the same cycle.
  assign o_alloc_ready   = (r_count < c_CNT_W'(DEPTH));
  assign w_head_pred     = r_entries[r_head].pred;
  assign o_resolve_ready = (r_count != '0) && r_entries[r_head].pred_vld;
  assign o_head_pred     = w_head_pred;

  assign w_alloc_acc  = i_alloc_valid & o_alloc_ready & ~i_flush;
  assign w_res_acc    = i_resolve_valid & o_resolve_ready & ~i_flush;

  assign o_pred_valid = w_alloc_acc;
  assign o_pred_pc    = i_alloc_pc;

  // Entry storage: fill the slot allocated last cycle with its prediction,
  // then write the newly allocated slot. The two never coincide because the
  // tail has already moved past the pending slot.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].pred_vld <= 1'b0;
      end
    end else begin
      if (r_pend_valid) begin
        r_entries[r_pend_idx].pred     <= i_pred_taken;
        r_entries[r_pend_idx].pred_vld <= 1'b1;
      end
      if (w_alloc_acc) begin
        r_entries[r_tail].pc       <= c_PC_W_MAX'(i_alloc_pc);
        r_entries[r_tail].pred_vld <= 1'b0;
      end
    end
  end

  // Pointers, occupancy and the one-deep prediction-capture pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
    end else begin
      r_pend_valid <= w_alloc_acc;
      if (w_alloc_acc) begin
        r_pend_idx <= r_tail;
        r_tail     <= r_tail + c_PTR_W'(1);
      end
      if (w_res_acc) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      unique case ({w_alloc_acc, w_res_acc})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered predictor update; flush does not cancel an update already
  // registered from the previous cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_update_valid <= 1'b0;
      r_update_pc    <= '0;
      r_result_taken <= 1'b0;
      r_mispredict   <= 1'b0;
    end else begin
      r_update_valid <= w_res_acc;
      r_mispredict   <= w_res_acc & (w_head_pred != i_resolve_taken);
      if (w_res_acc) begin
        r_update_pc    <= r_entries[r_head].pc[PC_W-1:0];
        r_result_taken <= i_resolve_taken;
      end
    end
  end

  assign o_update_valid = r_update_valid;
  assign o_update_pc    = r_update_pc;
  assign o_result_taken = r_result_taken;
  assign o_mispredict   = r_mispredict;
  assign o_count        = r_count;

`ifdef BIQ_STATS_EN
  biq_stats u_stats (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_update_valid (r_update_valid),
    .i_mispredict   (r_mispredict),
    .o_branch_cnt   (o_branch_cnt),
    .o_mispred_cnt  (o_mispred_cnt)
  );
`else
  assign o_branch_cnt  = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_inflight_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_inflight_queue
// Description : Self-checking bench for branch_inflight_queue. A reference
//               queue tracks allocated branches; resolves push expected
//               predictor updates to a scoreboard that is popped when the
//               DUT emits its registered update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_inflight_queue;

  localparam int DEPTH = 16;
  localparam int PC_W  = 64;

  logic                   i_clk;
  logic                   i_reset;
  logic                   i_alloc_valid;
  logic [PC_W-1:0]        i_alloc_pc;
  logic                   o_alloc_ready;
  logic                   o_pred_valid;
  logic [PC_W-1:0]        o_pred_pc;
  logic                   i_pred_taken;
  logic                   i_resolve_valid;
  logic                   i_resolve_taken;
  logic                   o_resolve_ready;
  logic                   o_update_valid;
  logic [PC_W-1:0]        o_update_pc;
  logic                   o_result_taken;
  logic                   o_mispredict;
  logic                   o_head_pred;
  logic [$clog2(DEPTH):0] o_count;
  logic                   i_flush;
  logic [31:0]            o_branch_cnt;
  logic [31:0]            o_mispred_cnt;

  branch_inflight_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_alloc_valid   (i_alloc_valid),
    .i_alloc_pc      (i_alloc_pc),
    .o_alloc_ready   (o_alloc_ready),
    .o_pred_valid    (o_pred_valid),
    .o_pred_pc       (o_pred_pc),
    .i_pred_taken    (i_pred_taken),
    .i_resolve_valid (i_resolve_valid),
    .i_resolve_taken (i_resolve_taken),
    .o_resolve_ready (o_resolve_ready),
    .o_update_valid  (o_update_valid),
    .o_update_pc     (o_update_pc),
    .o_result_taken  (o_result_taken),
    .o_mispredict    (o_mispredict),
    .o_head_pred     (o_head_pred),
    .o_count         (o_count),
    .i_flush         (i_flush),
    .o_branch_cnt    (o_branch_cnt),
    .o_mispred_cnt   (o_mispred_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] pc;
    logic        pred;
    logic        vld;
  } ment_t;

  typedef struct {
    logic [63:0] pc;
    logic        taken;
    logic        mis;
  } upd_t;

  ment_t mq[$];
  upd_t  sb[$];
  logic  m_pend;
  logic  exp_upd;
  int    m_br;
  int    m_mp;
  int    seg_mp;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational outputs, advance the reference model, then check the
  // registered update on the next falling edge.
  task automatic cycle(input logic av, input logic [63:0] apc, input logic pt,
                       input logic rv, input logic rt, input logic fl);
    logic  e_alloc;
    logic  e_ready;
    logic  e_res;
    ment_t e;
    upd_t  u;
    i_alloc_valid   = av;
    i_alloc_pc      = apc;
    i_pred_taken    = pt;
    i_resolve_valid = rv;
    i_resolve_taken = rt;
    i_flush         = fl;
    #1;
    e_ready = (mq.size() > 0) && mq[0].vld;
    e_alloc = av && (mq.size() < DEPTH) && !fl;
    e_res   = rv && e_ready && !fl;
    check("alloc_ready", 64'(o_alloc_ready), 64'(mq.size() < DEPTH));
    check("resolve_ready", 64'(o_resolve_ready), 64'(e_ready));
    check("count", 64'(o_count), 64'(mq.size()));
    check("pred_valid", 64'(o_pred_valid), 64'(e_alloc));
    if (e_alloc) check("pred_pc", o_pred_pc, apc);
    if (e_ready) check("head_pred", 64'(o_head_pred), 64'(mq[0].pred));
    exp_upd = e_res;
    if (fl) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        mq[mq.size()-1].pred = pt;
        mq[mq.size()-1].vld  = 1'b1;
      end
      if (e_res) begin
        e = mq.pop_front();
        u.pc    = e.pc;
        u.taken = rt;
        u.mis   = (e.pred != rt);
        sb.push_back(u);
      end
      if (e_alloc) begin
        e.pc   = apc;
        e.pred = 1'b0;
        e.vld  = 1'b0;
        mq.push_back(e);
      end
      m_pend = e_alloc;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check("update_valid", 64'(o_update_valid), 64'(exp_upd));
    if (o_update_valid && o_mispredict) seg_mp++;
    if (exp_upd && sb.size() > 0) begin
      u = sb.pop_front();
      check("update_pc", o_update_pc, u.pc);
      check("result_taken", 64'(o_result_taken), 64'(u.taken));
      check("mispredict", 64'(o_mispredict), 64'(u.mis));
      m_br++;
      if (u.mis) m_mp++;
    end else begin
      check("mispredict_idle", 64'(o_mispredict), 64'd0);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 64'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_stats(input string tag);
`ifdef BIQ_STATS_EN
    check({tag, "_branch_cnt"}, 64'(o_branch_cnt), 64'(m_br));
    check({tag, "_mispred_cnt"}, 64'(o_mispred_cnt), 64'(m_mp));
`else
    check({tag, "_branch_cnt"}, 64'(o_branch_cnt), 64'd0);
    check({tag, "_mispred_cnt"}, 64'(o_mispred_cnt), 64'd0);
`endif
  endtask

  task automatic do_reset();
    i_reset         = 1'b1;
    i_alloc_valid   = 1'b0;
    i_alloc_pc      = '0;
    i_pred_taken    = 1'b0;
    i_resolve_valid = 1'b0;
    i_resolve_taken = 1'b0;
    i_flush         = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    mq.delete();
    sb.delete();
    m_pend = 1'b0;
    m_br   = 0;
    m_mp   = 0;
    #1;
    check("rst_update_valid", 64'(o_update_valid), 64'd0);
    check("rst_update_pc", o_update_pc, 64'd0);
    check("rst_result_taken", 64'(o_result_taken), 64'd0);
    check("rst_mispredict", 64'(o_mispredict), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_alloc_ready", 64'(o_alloc_ready), 64'd1);
    check("rst_resolve_ready", 64'(o_resolve_ready), 64'd0);
    check_stats("rst");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    seg_mp   = 0;
    exp_upd  = 1'b0;
    @(negedge i_clk);
    do_reset();

    // Basic: alloc, capture taken prediction, resolve taken -> no mispredict.
    cycle(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'd0,    1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'd0,    1'b0, 1'b1, 1'b1, 1'b0);
    idle();

    // Fill to full with alternating predictions, refused 17th alloc,
    // then resolve all not-taken.
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 64'(32'h2000 + k * 4), ~k[0], 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 64'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_count", 64'(o_count), 64'(DEPTH));
    seg_mp = 0;
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle();
    check("mispredict_tally", 64'(seg_mp), 64'd8);

    // Full queue with simultaneous alloc and resolve: alloc refused.
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 64'(32'h4000 + k * 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    idle();
    cycle(1'b1, 64'h4100, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    for (int k = 0; k < DEPTH - 1; k++) begin
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    idle();

    // Pointer wrap at steady occupancy 3.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 64'(32'h5000 + k * 8), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 3; k < 43; k++) begin
      cycle(1'b1, 64'(32'h5000 + k * 8), 1'($urandom_range(0, 1)), 1'b1,
            1'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 64'd0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    idle();

    // Flush together with alloc and resolve; the earlier update still emits.
    cycle(1'b1, 64'h6000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h6010, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h6020, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 64'h6030, 1'b1, 1'b1, 1'b0, 1'b1);
    check("flush_count", 64'(o_count), 64'd0);
    repeat (3) idle();

    // Statistics: 5 branches, 2 mispredicts; flush keeps them, reset clears.
    do_reset();
    cycle(1'b1, 64'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h7004, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h7008, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h700c, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h7010, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'd0,    1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    repeat (2) idle();
    check_stats("stats");
    cycle(1'b1, 64'h7100, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) idle();
    check_stats("stats_flush");
    cycle(1'b1, 64'h7200, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (2) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no finish, expected finish before bound");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
